lut_scan: RTL and testbench
===========================

# lut_scan

Upstream sequencer for a 7-input LUT tree; this tree takes its 7-bit input bus on pins J1 and drives its single output on J3. On a start request the block sweeps every input code from 0 to 2^N-1 and waits a programmable settle time after each code. It then samples the LUT output and assembles the full truth table into a register for readback. It is the board-level harness that drives and characterises the LUT stage on iCE40.

## Interface
Parameters:
- N, default 7: LUT input width; addresses 0..2^N-1.
- SETTLE, default 1: cycles the address is held before sampling. Legal range 1..15.
- GOLDEN, default {2^N/2{2'b10}}: expected truth table. Exists only with LUT_SCAN_CHECK_EN.

Ports:
- CLK, in, 1: sole clock; all state changes on the rising edge.
- RESET, in, 1: asynchronous, active-high reset.
- start, in, 1: scan request; accepted only in IDLE.
- lut_o, in, 1: LUT output (J3 of the LUT stage).
- addr, out, N: LUT input code (J1 of the LUT stage); registered.
- busy, out, 1: high from the cycle after start is accepted until DONE is left.
- done, out, 1: one-cycle pulse when the scan completes.
- valid, out, 1: truth contents are complete and stable.
- truth, out, 2^N: captured table; bit i = lut_o sampled while addr == i.
- match, out, 1: truth == GOLDEN, qualified by valid. Exists only with LUT_SCAN_CHECK_EN.

## Operation
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - If start is high, go to SETTLE.
  - On the same transition: addr←0, settle counter←SETTLE-1, truth←0, valid←0.
- SETTLE:
  - Counter decrements each cycle.
  - When the counter is 0, go to SAMPLE.
- SAMPLE:
  - truth[addr]←lut_o.
  - If addr == 2^N-1, go to DONE.
  - Otherwise addr←addr+1, counter←SETTLE-1, go to SETTLE.
- DONE:
  - done=1 and valid←1 for one cycle.
  - Return to IDLE.
- addr does not wrap: it holds 2^N-1 after the scan until the next accepted start.
- start is ignored in SETTLE, SAMPLE and DONE; it is not queued.
- start held high continuously re-triggers a scan on every IDLE cycle. This is by design.
- truth and valid hold after DONE until the next accepted start or RESET.
- RESET at any time, including mid-scan:
  - State→IDLE.
  - addr=0, truth=0, busy=0, done=0, valid=0, counter=0.
  - No partial result is kept.

## Timing
- Reset values: addr 0, busy 0, done 0, valid 0, truth 0, match 0.
- Start sampled high at edge k:
  - busy=1 and addr=0 from edge k+1.
  - Each address occupies exactly SETTLE+1 cycles: SETTLE cycles in SETTLE, then 1 cycle in SAMPLE.
- The LUT stage is combinational, so lut_o must be valid SETTLE cycles after addr changes.
- done is high in the cycle after edge k+2^N·(SETTLE+1)+1.
  - Defaults (N=7, SETTLE=1): done follows edge k+257.
- valid rises on the same edge that done falls, and busy falls on that edge too.
- A new start is accepted on the first IDLE cycle after DONE.

## Configuration
- Macro LUT_SCAN_CHECK_EN.
- Defined:
  - Adds parameter GOLDEN and port match.
  - match is registered, updated on the DONE→IDLE edge, and equals valid && (truth == GOLDEN).
  - match clears with valid, on start acceptance or RESET.
- Undefined: no GOLDEN, no match port, no comparator logic.

## Structure
- Package lut_scan_pkg:
  - State enum lut_scan_state_t (IDLE, SETTLE, SAMPLE, DONE).
  - Constant LUT_SCAN_CNT_W = 4.
  - Default-width constants for N=7.
- Sub-module lut_scan_ctr:
  - Loadable down-counter of width LUT_SCAN_CNT_W.
  - Ports load, load_val, zero.
  - Instantiated once for the settle count.
- Top-level lut_scan holds the FSM, the address register and the truth register.

## Test plan
- Reset then idle, start=0 for 20 cycles → addr=0, busy=0, done=0, truth=0.
- Defaults, lut_o model = addr[0], pulse start at edge 0:
  - done pulses for exactly one cycle after edge 257.
  - truth = 128'hAAAA…AAAA, valid=1.
  - With LUT_SCAN_CHECK_EN and default GOLDEN: match=1.
- Same scan with lut_o = addr[6] → truth upper 64 bits all 1, lower 64 bits all 0; match=0 with the macro defined.
- SETTLE=3:
  - Each addr value is held exactly 4 cycles.
  - A lut_o model that is correct only from the 3rd cycle after an addr change still yields the correct truth.
  - done follows edge 513.
- Pulse start again at cycles 10, 100 and 200 mid-scan → ignored; a single done after edge 257 with correct truth.
- Assert RESET at cycle 60 mid-scan, then start at cycle 70:
  - Outputs return to reset values immediately.
  - A fresh full scan completes, with done after edge 327.

Source files
------------

// File: rtl/lut_scan_pkg.sv
// Shared types and constants for the lut_scan truth-table sequencer.
// The optional golden comparator in lut_scan is enabled with LUT_SCAN_CHECK_EN.
package lut_scan_pkg;

    typedef enum logic [1:0] {
        LS_IDLE   = 2'b00,
        LS_SETTLE = 2'b01,
        LS_SAMPLE = 2'b10,
        LS_DONE   = 2'b11
    } lut_scan_state_t;

    localparam int LUT_SCAN_CNT_W      = 4;
    localparam int LUT_SCAN_N_DEF      = 7;
    localparam int LUT_SCAN_SETTLE_DEF = 1;

endpackage

// File: rtl/lut_scan_ctr.sv
// Loadable down-counter used to time the settle interval of each LUT address.
// Saturates at zero; zero flags the end of the interval.
module lut_scan_ctr
    import lut_scan_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic                      dec,
    input  logic [LUT_SCAN_CNT_W-1:0] load_val,
    output logic                      zero
);

    localparam logic [LUT_SCAN_CNT_W-1:0] CNT_ZERO = {LUT_SCAN_CNT_W{1'b0}};
    localparam logic [LUT_SCAN_CNT_W-1:0] CNT_ONE  = {{(LUT_SCAN_CNT_W-1){1'b0}}, 1'b1};

    logic [LUT_SCAN_CNT_W-1:0] cnt_q;
    logic [LUT_SCAN_CNT_W-1:0] cnt_d;

    // next count: load wins over decrement
    always_comb begin
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != CNT_ZERO)) begin
            cnt_d = cnt_q - CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= CNT_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == CNT_ZERO);

endmodule

// File: rtl/lut_scan.sv
// Sweeps every LUT input code, waits SETTLE cycles per code and captures the truth table.
// Define LUT_SCAN_CHECK_EN to add the GOLDEN parameter and the registered match output.
module lut_scan
    import lut_scan_pkg::*;
#(
    parameter int N = LUT_SCAN_N_DEF,
`ifdef LUT_SCAN_CHECK_EN
    parameter logic [(2**N)-1:0] GOLDEN = {(2**N/2){2'b10}},
`endif
    parameter int SETTLE = LUT_SCAN_SETTLE_DEF
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                start,
    input  logic                lut_o,
    output logic [N-1:0]        addr,
    output logic                busy,
    output logic                done,
    output logic                valid,
`ifdef LUT_SCAN_CHECK_EN
    output logic                match,
`endif
    output logic [(2**N)-1:0]   truth
);

    localparam int TW = 2**N;
    localparam logic [N-1:0] ADDR_ZERO = {N{1'b0}};
    localparam logic [N-1:0] ADDR_ONE  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] ADDR_LAST = {N{1'b1}};
    localparam logic [LUT_SCAN_CNT_W-1:0] SETTLE_RELOAD = LUT_SCAN_CNT_W'(SETTLE - 1);

    lut_scan_state_t state_q, state_d;
    logic            start_q;
    logic [N-1:0]    addr_q, addr_d;
    logic [TW-1:0]   truth_q, truth_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            valid_q, valid_d;
    logic            match_q, match_d;
    logic            ctr_load_s, ctr_dec_s, ctr_zero_s;

    lut_scan_ctr u_settle_ctr (
        .clk      (CLK),
        .rst      (RESET),
        .load     (ctr_load_s),
        .dec      (ctr_dec_s),
        .load_val (SETTLE_RELOAD),
        .zero     (ctr_zero_s)
    );

    // scan sequencing; start is registered first so every output lags its cause by one edge
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        truth_d    = truth_q;
        valid_d    = valid_q;
        match_d    = match_q;
        ctr_load_s = 1'b0;
        ctr_dec_s  = 1'b0;
        case (state_q)
            LS_IDLE: begin
                if (start_q) begin
                    state_d    = LS_SETTLE;
                    addr_d     = ADDR_ZERO;
                    truth_d    = {TW{1'b0}};
                    valid_d    = 1'b0;
                    match_d    = 1'b0;
                    ctr_load_s = 1'b1;
                end else begin
                    state_d = LS_IDLE;
                end
            end
            LS_SETTLE: begin
                if (ctr_zero_s) begin
                    state_d = LS_SAMPLE;
                end else begin
                    ctr_dec_s = 1'b1;
                end
            end
            LS_SAMPLE: begin
                truth_d[addr_q] = lut_o;
                if (addr_q == ADDR_LAST) begin
                    state_d = LS_DONE;
                end else begin
                    addr_d     = addr_q + ADDR_ONE;
                    ctr_load_s = 1'b1;
                    state_d    = LS_SETTLE;
                end
            end
            LS_DONE: begin
                state_d = LS_IDLE;
                valid_d = 1'b1;
`ifdef LUT_SCAN_CHECK_EN
                match_d = (truth_q == GOLDEN);
`else
                match_d = 1'b0;
`endif
            end
            default: begin
                state_d = LS_IDLE;
            end
        endcase
        busy_d = (state_d != LS_IDLE);
        done_d = (state_d == LS_DONE);
    end

    // state and output registers
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= LS_IDLE;
            start_q <= 1'b0;
            addr_q  <= ADDR_ZERO;
            truth_q <= {TW{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start;
            addr_q  <= addr_d;
            truth_q <= truth_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            match_q <= match_d;
        end
    end

    assign addr  = addr_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign valid = valid_q;
    assign truth = truth_q;
`ifdef LUT_SCAN_CHECK_EN
    assign match = match_q;
`endif

endmodule

// File: tb/tb_lut_scan.sv
// Self-checking bench for lut_scan: a timing/table model checked every cycle plus literal expectations.
module tb_lut_scan;

    localparam int N = 7;
    localparam int W = 128;
`ifdef LUT_SCAN_CHECK_EN
    localparam logic [W-1:0] GOLD = {64{2'b10}};
`endif

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    logic start1 = 1'b0;
    logic start3 = 1'b0;
    logic lut1, lut3;
    logic [N-1:0] addr1, addr3;
    logic busy1, busy3, done1, done3, valid1, valid3;
    logic [W-1:0] truth1, truth3;
`ifdef LUT_SCAN_CHECK_EN
    logic match1, match3;
`endif

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int fsel [2];
    bit act [2];
    bit pend [2];
    int sa [2];
    int fs [2];
    int pfs [2];
    int done_cnt [2];
    int done_edge [2];
    int hold5 = 0;
    int age3 = 0;
    logic [N-1:0] last3 = '0;
    logic lastb3 = 1'b0;
    int k;

    always #5 CLK = ~CLK;

    function automatic logic lutf(input int sel, input logic [N-1:0] a);
        case (sel)
            0: return a[0];
            1: return a[6];
            default: return ^(a & 7'h2D);
        endcase
    endfunction

    function automatic int settle(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic int per(input int d);
        return W * (settle(d) + 1);
    endfunction

    function automatic logic st_of(input int d);
        return (d == 0) ? start1 : start3;
    endfunction

    // LUT stage emulation: dut3's LUT only settles on the 3rd cycle after an address change
    assign lut1 = lutf(fsel[0], addr1);
    assign lut3 = (age3 >= 3) ? lutf(fsel[1], addr3) : ~lutf(fsel[1], addr3);

    lut_scan #(.N(N), .SETTLE(1)) dut1 (
        .CLK(CLK), .RESET(RESET), .start(start1), .lut_o(lut1), .addr(addr1),
        .busy(busy1), .done(done1), .valid(valid1),
`ifdef LUT_SCAN_CHECK_EN
        .match(match1),
`endif
        .truth(truth1));

    lut_scan #(.N(N), .SETTLE(3)) dut3 (
        .CLK(CLK), .RESET(RESET), .start(start3), .lut_o(lut3), .addr(addr3),
        .busy(busy3), .done(done3), .valid(valid3),
`ifdef LUT_SCAN_CHECK_EN
        .match(match3),
`endif
        .truth(truth3));

    task automatic cmp(input string nm, input int d, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s dut%0d cyc=%0d got=%h want=%h", nm, d, cyc, got, exp);
        end
    endtask

    function automatic logic [W-1:0] exp_truth(input int d, input int e);
        logic [W-1:0] t;
        int s1;
        t = '0;
        s1 = settle(d) + 1;
        for (int i = 0; i < W; i++) begin
            if (e >= s1 * (i + 1)) t[i] = lutf(fs[d], N'(i));
        end
        return t;
    endfunction

    task automatic check_dut(input int d, input logic [N-1:0] a, input logic b, input logic dn,
                             input logic v, input logic [W-1:0] tr);
        int e, q;
        logic [N-1:0] ea;
        logic eb, edn, ev;
        logic [W-1:0] et;
        if (RESET || !act[d]) begin
            ea = '0; eb = 1'b0; edn = 1'b0; ev = 1'b0; et = '0;
        end else begin
            e = (cyc - 1) - sa[d];
            eb = (e <= per(d));
            edn = (e == per(d));
            ev = (e >= per(d) + 1);
            q = e / (settle(d) + 1);
            if (q > W - 1) q = W - 1;
            ea = N'(q);
            et = exp_truth(d, e);
        end
        cmp("addr", d, W'(a), W'(ea));
        cmp("busy", d, W'(b), W'(eb));
        cmp("done", d, W'(dn), W'(edn));
        cmp("valid", d, W'(v), W'(ev));
        cmp("truth", d, tr, et);
    endtask

`ifdef LUT_SCAN_CHECK_EN
    task automatic check_match(input int d, input logic m);
        logic em;
        if (RESET || !act[d]) em = 1'b0;
        else em = ((cyc - 1) - sa[d] >= per(d) + 1) && (exp_truth(d, per(d) + 1) == GOLD);
        cmp("match", d, W'(m), W'(em));
    endtask
`endif

    // model: track which start edges are accepted and when each scan began
    initial begin
        forever begin
            @(posedge CLK);
            for (int d = 0; d < 2; d++) begin
                if (RESET) begin
                    act[d] = 1'b0;
                    pend[d] = 1'b0;
                end else if (pend[d]) begin
                    act[d] = 1'b1;
                    sa[d] = cyc;
                    fs[d] = pfs[d];
                    pend[d] = 1'b0;
                end else if (st_of(d) && (!act[d] || (cyc - sa[d] >= per(d) + 1))) begin
                    pend[d] = 1'b1;
                    pfs[d] = fsel[d];
                end
            end
            cyc = cyc + 1;
        end
    end

    // settle-age tracker for dut3's slow LUT
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if ((addr3 !== last3) || (busy3 && !lastb3)) age3 = 1;
            else if (age3 < 15) age3 = age3 + 1;
            last3 = addr3;
            lastb3 = busy3;
        end
    end

    // per-cycle compare against the model
    initial begin
        forever begin
            @(negedge CLK);
            check_dut(0, addr1, busy1, done1, valid1, truth1);
            check_dut(1, addr3, busy3, done3, valid3, truth3);
`ifdef LUT_SCAN_CHECK_EN
            check_match(0, match1);
            check_match(1, match3);
`endif
            if (done1 === 1'b1) begin done_cnt[0]++; done_edge[0] = cyc - 1; end
            if (done3 === 1'b1) begin done_cnt[1]++; done_edge[1] = cyc - 1; end
            if (busy3 === 1'b1 && addr3 == 7'd5) hold5++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #2;
    endtask

    task automatic run_until(input int t);
        while (cyc - 1 < t) step(1);
    endtask

    task automatic pulse(input int d, input int sel, output int ks);
        fsel[d] = sel;
        done_cnt[d] = 0;
        if (d == 0) start1 = 1'b1; else start3 = 1'b1;
        step(1);
        ks = cyc - 1;
        start1 = 1'b0;
        start3 = 1'b0;
    endtask

    task automatic wait_done(input int d, input int ks, input int off);
        while (done_cnt[d] == 0 && (cyc - 1) < ks + off + 20) step(1);
        if (done_cnt[d] == 0) begin
            total++;
            bad++;
            $display("FAIL done_timeout dut%0d cyc=%0d got=none want=edge %0d", d, cyc, ks + off);
        end else begin
            cmp("done_edge", d, W'(done_edge[d] - ks), W'(off));
        end
        step(10);
        cmp("done_once", d, W'(done_cnt[d]), W'(1));
    endtask

    initial begin
        step(3);
        RESET = 1'b0;
        step(20);
        cmp("idle_addr", 0, W'(addr1), W'(0));
        cmp("idle_busy", 0, W'(busy1), W'(0));
        cmp("idle_done", 0, W'(done1), W'(0));
        cmp("idle_truth", 0, truth1, '0);

        // addr[0] pattern, defaults
        pulse(0, 0, k);
        wait_done(0, k, 257);
        cmp("truth_a0", 0, truth1, 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA);
        cmp("valid_a0", 0, W'(valid1), W'(1));
        cmp("addr_hold", 0, W'(addr1), W'(127));
`ifdef LUT_SCAN_CHECK_EN
        cmp("match_a0", 0, W'(match1), W'(1));
`endif

        // addr[6] pattern
        pulse(0, 1, k);
        wait_done(0, k, 257);
        cmp("truth_a6", 0, truth1, 128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000);
`ifdef LUT_SCAN_CHECK_EN
        cmp("match_a6", 0, W'(match1), W'(0));
`endif

        // SETTLE=3 with a slow-settling LUT
        hold5 = 0;
        pulse(1, 0, k);
        wait_done(1, k, 513);
        cmp("truth_s3", 1, truth3, 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA);
        cmp("hold_s3", 1, W'(hold5), W'(4));

        // start pulses mid-scan and during DONE are ignored
        pulse(0, 2, k);
        run_until(k + 9);   start1 = 1'b1; step(1); start1 = 1'b0;
        run_until(k + 99);  start1 = 1'b1; step(1); start1 = 1'b0;
        run_until(k + 199); start1 = 1'b1; step(1); start1 = 1'b0;
        run_until(k + 256); start1 = 1'b1; step(1); start1 = 1'b0;
        wait_done(0, k, 257);
        cmp("busy_after_d", 0, W'(busy1), W'(0));

        // reset mid-scan, then a fresh scan
        pulse(0, 0, k);
        run_until(k + 59);
        RESET = 1'b1;
        #1;
        cmp("rst_busy", 0, W'(busy1), W'(0));
        cmp("rst_addr", 0, W'(addr1), W'(0));
        cmp("rst_truth", 0, truth1, '0);
        step(1);
        RESET = 1'b0;
        run_until(k + 69);
        fsel[0] = 0;
        start1 = 1'b1; step(1); start1 = 1'b0;
        wait_done(0, k, 327);
        cmp("truth_rst", 0, truth1, 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
